block_ram_dp: RTL and testbench

//  Parametrised simple-dual-port block RAM: one write port with per-lane byte enables,
//  one independent read port. Read and write run in the same cycle (no read stall on write).

---
 rtl/block_ram_dp.sv | 138 +++++++++++++
 tb/tb_block_ram_dp.sv | 210 +++++++++++++++++++++
 2 files changed

// File: rtl/block_ram_dp.sv
// Simple dual-port block RAM: byte-lane write port, independent read port,
// selectable read latency, read-during-write mode and optional zero-fill.
module block_ram_dp #(
  parameter           INIT_FILE      = "",
  parameter int       MEM_SIZE       = 512,
  parameter int       ADDR_WD        = 9,
  parameter int       DATA_WD        = 36,
  parameter int       LANE_WD        = 9,
  parameter int       RD_LATENCY     = 1,
  parameter int       RDW_MODE       = 0,
  parameter int       CLEAR_ON_RESET = 0,
  localparam int      NUM_LANES      = DATA_WD / LANE_WD
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 rd_en,
  input  logic [ADDR_WD-1:0]   rdaddr,
  input  logic                 wr_en,
  input  logic [NUM_LANES-1:0] wr_be,
  input  logic [ADDR_WD-1:0]   wraddr,
  input  logic [DATA_WD-1:0]   datain,
  output logic [DATA_WD-1:0]   dataout,
  output logic                 rd_valid,
  output logic                 init_busy,
  output logic                 addr_err
);

  typedef enum logic {CLEAR, READY} state_t;

  localparam logic [ADDR_WD:0] LIMIT =
    (ADDR_WD+1)'(MEM_SIZE);
  localparam logic [ADDR_WD-1:0] LAST =
    ADDR_WD'(MEM_SIZE - 1);

  logic [DATA_WD-1:0] mem [MEM_SIZE];

  state_t             state;
  logic [ADDR_WD-1:0] cnt;
  logic               ready;
  logic               rd_in;
  logic               wr_in;
  logic               rd_req;
  logic               wr_ok;
  logic               rd_ok;
  logic [DATA_WD-1:0] rd_word;
  logic [DATA_WD-1:0] s1_data;
  logic               s1_valid;

  assign ready  = (state == READY);
  assign rd_in  = ({1'b0, rdaddr} < LIMIT);
  assign wr_in  = ({1'b0, wraddr} < LIMIT);
  assign rd_req = ready & rd_en;
  assign rd_ok  = rd_req & rd_in;
  assign wr_ok  = ready & wr_en & wr_in;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= (CLEAR_ON_RESET != 0) ? CLEAR : READY;
      cnt       <= '0;
      init_busy <= (CLEAR_ON_RESET != 0);
    end else if (state == CLEAR) begin
      cnt <= cnt + 1'b1;
      if (cnt == LAST) begin
        state     <= READY;
        init_busy <= 1'b0;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (state == CLEAR) begin
      mem[cnt] <= '0;
    end else if (wr_ok) begin
      for (int i = 0; i < NUM_LANES; i++) begin
        if (wr_be[i]) begin
          mem[wraddr][i*LANE_WD +: LANE_WD] <=
            datain[i*LANE_WD +: LANE_WD];
        end
      end
    end
  end

  always_comb begin
    rd_word = '0;
    if (rd_ok) begin
      rd_word = mem[rdaddr];
      if (RDW_MODE == 1 && wr_ok && wraddr == rdaddr) begin
        for (int i = 0; i < NUM_LANES; i++) begin
          if (wr_be[i]) begin
            rd_word[i*LANE_WD +: LANE_WD] =
              datain[i*LANE_WD +: LANE_WD];
          end
        end
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      s1_data  <= '0;
      s1_valid <= 1'b0;
      addr_err <= 1'b0;
    end else begin
      s1_valid <= rd_req;
      if (rd_req) begin
        s1_data <= rd_word;
      end
      addr_err <= ready &
        ((rd_en & ~rd_in) | (wr_en & ~wr_in));
    end
  end

  generate
    if (RD_LATENCY == 2) begin : g_lat2
      logic [DATA_WD-1:0] s2_data;
      logic               s2_valid;

      always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
          s2_data  <= '0;
          s2_valid <= 1'b0;
        end else begin
          s2_valid <= s1_valid;
          if (s1_valid) begin
            s2_data <= s1_data;
          end
        end
      end

      assign dataout  = s2_data;
      assign rd_valid = s2_valid;
    end else begin : g_lat1
      assign dataout  = s1_data;
      assign rd_valid = s1_valid;
    end
  endgenerate

endmodule

// File: tb/tb_block_ram_dp.sv
// Scoreboard bench: two RAM instances (latency 1 read-first, latency 2
// write-first) share stimulus; a lane-level model predicts every read.
module tb_block_ram_dp;

    localparam int DW = 36;
    localparam int AW = 9;
    localparam int MS = 300;
    localparam int NL = 4;
    localparam int LW = 9;

    logic          clk = 1'b0;
    logic          rst_n = 1'b0;
    logic          rd_en = 1'b0;
    logic [AW-1:0] rdaddr = '0;
    logic          wr_en = 1'b0;
    logic [NL-1:0] wr_be = '0;
    logic [AW-1:0] wraddr = '0;
    logic [DW-1:0] datain = '0;

    logic [DW-1:0] dout_a, dout_b;
    logic          val_a, val_b, busy_a, busy_b, err_a, err_b;

    logic [DW-1:0] model [MS];
    logic [DW-1:0] qa [$];
    logic [DW-1:0] qb [$];
    logic [DW-1:0] last_a = '0;
    logic [DW-1:0] last_b = '0;
    int            errors = 0;
    int            checks = 0;

    always #5 clk = ~clk;

    block_ram_dp #(
        .INIT_FILE(""), .MEM_SIZE(MS), .ADDR_WD(AW), .DATA_WD(DW), .LANE_WD(LW),
        .RD_LATENCY(1), .RDW_MODE(0), .CLEAR_ON_RESET(1)
    ) dut_a (
        .clk(clk), .rst_n(rst_n), .rd_en(rd_en), .rdaddr(rdaddr),
        .wr_en(wr_en), .wr_be(wr_be), .wraddr(wraddr), .datain(datain),
        .dataout(dout_a), .rd_valid(val_a), .init_busy(busy_a), .addr_err(err_a)
    );

    block_ram_dp #(
        .INIT_FILE(""), .MEM_SIZE(MS), .ADDR_WD(AW), .DATA_WD(DW), .LANE_WD(LW),
        .RD_LATENCY(2), .RDW_MODE(1), .CLEAR_ON_RESET(1)
    ) dut_b (
        .clk(clk), .rst_n(rst_n), .rd_en(rd_en), .rdaddr(rdaddr),
        .wr_en(wr_en), .wr_be(wr_be), .wraddr(wraddr), .datain(datain),
        .dataout(dout_b), .rd_valid(val_b), .init_busy(busy_b), .addr_err(err_b)
    );

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got=%h exp=%h", tag, got, exp);
        end
    endtask

    always @(negedge clk) begin
        if (val_a) begin
            if (qa.size() == 0) chk("a_spurious_valid", 1, 0);
            else begin
                last_a = qa.pop_front();
                chk("a_rd_data", dout_a, last_a);
            end
        end
        if (val_b) begin
            if (qb.size() == 0) chk("b_spurious_valid", 1, 0);
            else begin
                last_b = qb.pop_front();
                chk("b_rd_data", dout_b, last_b);
            end
        end
    end

    // Called at a falling edge; returns at the next falling edge.
    task automatic step(input logic rd, input int ra, input logic wr,
                        input logic [NL-1:0] be, input int wa, input logic [DW-1:0] d);
        logic [DW-1:0] ea;
        logic [DW-1:0] eb;
        logic          ri, wi, ee;
        rd_en  = rd;
        rdaddr = ra[AW-1:0];
        wr_en  = wr;
        wr_be  = be;
        wraddr = wa[AW-1:0];
        datain = d;
        ri = (ra < MS);
        wi = (wa < MS);
        ea = '0;
        if (ri) ea = model[ra];
        eb = ea;
        if (wr && wi && ri && ra == wa) begin
            for (int i = 0; i < NL; i++)
                if (be[i]) eb[i*LW +: LW] = d[i*LW +: LW];
        end
        if (rd) begin
            qa.push_back(ea);
            qb.push_back(eb);
        end
        ee = (rd && !ri) || (wr && !wi);
        if (wr && wi) begin
            for (int i = 0; i < NL; i++)
                if (be[i]) model[wa][i*LW +: LW] = d[i*LW +: LW];
        end
        @(negedge clk);
        chk("a_addr_err", err_a, ee);
        chk("b_addr_err", err_b, ee);
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) step(0, 0, 0, '0, 0, '0);
    endtask

    task automatic sweep(input logic poke);
        int n;
        n = 0;
        rst_n = 1'b1;
        rd_en = poke;
        rdaddr = 9'd5;
        wr_en = poke;
        wr_be = '1;
        wraddr = 9'd5;
        datain = '1;
        while (busy_a && n < 1000) begin
            @(negedge clk);
            n++;
        end
        chk("sweep_len", n, MS);
        chk("b_busy_done", busy_b, 0);
        rd_en = 1'b0;
        wr_en = 1'b0;
        foreach (model[i]) model[i] = '0;
    endtask

    initial begin
        repeat (3) @(negedge clk);
        chk("rst_dout_a", dout_a, 0);
        chk("rst_valid_a", val_a, 0);
        chk("rst_err_a", err_a, 0);
        chk("rst_busy_a", busy_a, 1);
        chk("rst_dout_b", dout_b, 0);
        chk("rst_valid_b", val_b, 0);

        // Writes and reads offered during the sweep must be ignored.
        sweep(1'b1);
        step(1, 5, 0, '0, 0, '0);
        step(1, 0, 0, '0, 0, '0);
        step(1, 299, 0, '0, 0, '0);

        step(0, 0, 1, 4'hF, 5, 36'hFFFFFFFFF);
        step(0, 0, 1, 4'b0101, 5, 36'h0);
        step(1, 5, 0, '0, 0, '0);
        idle(2);
        chk("lane_merge", model[5], 36'hFF803FE00);
        step(0, 0, 1, 4'h0, 5, 36'h0);
        step(1, 5, 0, '0, 0, '0);

        step(0, 0, 1, 4'hF, 7, 36'h123456789);
        step(1, 7, 1, 4'hF, 7, 36'hABCDEF012);
        step(1, 7, 1, 4'b0011, 7, 36'h0);
        step(1, 7, 0, '0, 0, '0);

        step(0, 0, 1, 4'hF, 310, 36'hFFFFFFFFF);
        step(1, 400, 0, '0, 0, '0);
        step(1, 310, 1, 4'hF, 511, 36'h1);
        step(1, 299, 1, 4'hF, 299, 36'h0CAFEBABE);
        step(1, 299, 0, '0, 0, '0);
        idle(3);

        for (int k = 0; k < 40; k++) begin
            step(1'($urandom_range(0, 1)), int'($urandom_range(0, 319)),
                 1'($urandom_range(0, 1)), 4'($urandom_range(0, 15)),
                 int'($urandom_range(0, 319)),
                 {4'($urandom()), 32'($urandom())});
        end
        step(1, 5, 0, '0, 0, '0);
        idle(4);
        chk("a_hold_data", dout_a, last_a);
        chk("b_hold_data", dout_b, last_b);
        chk("a_idle_valid", val_a, 0);
        chk("b_idle_valid", val_b, 0);

        // Abort reads in flight: nothing may surface after reset.
        rd_en = 1'b1;
        rdaddr = 9'd5;
        @(posedge clk);
        #1 rdaddr = 9'd7;
        #1 rst_n = 1'b0;
        qa.delete();
        qb.delete();
        #1;
        chk("abort_dout_a", dout_a, 0);
        chk("abort_dout_b", dout_b, 0);
        chk("abort_valid_b", val_b, 0);
        chk("abort_busy_a", busy_a, 1);
        rd_en = 1'b0;
        repeat (3) @(negedge clk);
        sweep(1'b0);
        step(1, 5, 0, '0, 0, '0);
        step(1, 7, 0, '0, 0, '0);
        idle(4);

        chk("a_queue_drained", qa.size(), 0);
        chk("b_queue_drained", qb.size(), 0);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
